axis_pkt_checker: RTL and testbench

- Synthesizable AXI-Stream sink: the receiving end of the pipeline's packet-generator traffic.
- Sits after the RMT pipeline output (m_axis of the pipeline feeds s_axis here), on hardware or in simulation.
- Per packet it skips the header beat, checks that each payload beat carries an incrementing sequence value, and checks tkeep shape and packet length.
- Keeps packet, byte and error statistics and captures the first mismatch for debug readout.

---
 rtl/axis_pkt_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_axis_pkt_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_checker.sv
// -----------------------------------------------------------------------------
// axis_pkt_checker
//
// AXI-Stream sink for packet-generator traffic. Each packet is one header beat
// (not checked) followed by payload beats whose low 64 data bits must equal
// cfg_seq_base + beat index, with all higher data bits zero. Beat tkeep shape
// and packet length are checked. Packet, byte and error statistics are kept,
// and the first error after reset or clr_stats is captured for readout.
//
// Optional build macro: AXIS_PKT_CHECKER_BP_EN
//   Defined:   a 16-bit LFSR throttles s_axis_tready (~75% duty) to exercise
//              upstream backpressure.
//   Undefined: s_axis_tready is 1 whenever areset is low.
//
// Ports:
//   clk, areset        clock, synchronous active-high reset
//   s_axis_*           AXI-Stream slave (tuser accepted but ignored)
//   cfg_seq_base       expected payload beat k low word is cfg_seq_base + k
//   cfg_pkt_beats      expected beats per packet incl. header (0 acts as 1)
//   clr_stats          synchronous clear of statistics and error capture
//   stat_pkt_cnt       packets completed (wraps)
//   stat_byte_cnt      bytes accepted, popcount of tkeep (wraps)
//   stat_err_cnt       erroneous packets (saturates)
//   err_flag           sticky first-error flag
//   err_code           first-error cause: [0] data [1] tkeep [2] short [3] long
//   err_got, err_exp   low data word and expected value at the first bad beat
// -----------------------------------------------------------------------------
module axis_pkt_checker #(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int CNT_WIDTH            = 64
) (
   input  logic                              clk,
   input  logic                              areset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   input  logic [63:0]                       cfg_seq_base,
   input  logic [15:0]                       cfg_pkt_beats,
   input  logic                              clr_stats,
   output logic [CNT_WIDTH-1:0]              stat_pkt_cnt,
   output logic [CNT_WIDTH-1:0]              stat_byte_cnt,
   output logic [31:0]                       stat_err_cnt,
   output logic                              err_flag,
   output logic [3:0]                        err_code,
   output logic [63:0]                       err_got,
   output logic [63:0]                       err_exp
);

   localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

   localparam logic [1:0] ST_HDR     = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;

   function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_W-1:0] k);
      logic [CNT_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < KEEP_W; i++) c = c + CNT_WIDTH'(k[i]);
      return c;
   endfunction

   logic [1:0]           state_q, state_d;
   logic [15:0]          beat_idx_q, beat_idx_d;
   logic                 pkt_err_q, pkt_err_d;
   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
   logic [31:0]          err_cnt_q, err_cnt_d;
   logic                 err_flag_q, err_flag_d;
   logic [3:0]           err_code_q, err_code_d;
   logic [63:0]          err_got_q, err_got_d;
   logic [63:0]          err_exp_q, err_exp_d;

   logic                 acc;
   logic [15:0]          eff_beats;
   logic [16:0]          idx_next;
   logic [63:0]          exp_seq;
   logic                 hi_nz;
   logic                 keep_contig;
   logic [3:0]           beat_err;
   logic                 pkt_bad;

   logic unused_tuser;
   assign unused_tuser = ^s_axis_tuser;

`ifdef AXIS_PKT_CHECKER_BP_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, free-running every cycle.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (areset) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end

   assign s_axis_tready = !areset && (lfsr_q[1:0] != 2'b00);
`else
   assign s_axis_tready = !areset;
`endif

   assign acc       = s_axis_tvalid && s_axis_tready;
   assign eff_beats = (cfg_pkt_beats == 16'd0) ? 16'd1 : cfg_pkt_beats;
   assign idx_next  = {1'b0, beat_idx_q} + 17'd1;
   // beat_idx_q is stale while in HDR; the header corresponds to index 0.
   assign exp_seq   = cfg_seq_base + ((state_q == ST_HDR) ? 64'd0 : 64'(beat_idx_q));
   assign hi_nz     = (s_axis_tdata >> 64) != '0;
   // Contiguous-from-bit-0 masks are exactly those where mask+1 clears every set bit.
   assign keep_contig = (s_axis_tkeep != '0) &&
                        (((s_axis_tkeep + KEEP_W'(1)) & s_axis_tkeep) == '0);

   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      pkt_err_d  = pkt_err_q;
      beat_err   = 4'b0000;
      case (state_q)
         ST_HDR: begin
            if (acc) begin
               beat_idx_d = 16'd1;
               if (s_axis_tlast) begin
                  if (eff_beats > 16'd1) beat_err[2] = 1'b1;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (acc) begin
               if ((s_axis_tdata[63:0] != exp_seq) || hi_nz) beat_err[0] = 1'b1;
               if (s_axis_tlast) begin
                  if (!keep_contig) beat_err[1] = 1'b1;
                  if (idx_next < {1'b0, eff_beats})      beat_err[2] = 1'b1;
                  else if (idx_next > {1'b0, eff_beats}) beat_err[3] = 1'b1;
                  state_d = ST_HDR;
               end else begin
                  if (s_axis_tkeep != '1) beat_err[1] = 1'b1;
                  if (idx_next >= {1'b0, eff_beats}) begin
                     beat_err[3] = 1'b1;
                     state_d     = ST_DRAIN;
                  end
               end
               beat_idx_d = idx_next[15:0];
            end
         end
         ST_DRAIN: begin
            if (acc && s_axis_tlast) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
      // Per-packet error is remembered until tlast so the packet counts once.
      if (acc) pkt_err_d = s_axis_tlast ? 1'b0 : (pkt_err_q | (|beat_err));
   end

   assign pkt_bad = pkt_err_q | (|beat_err);

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      byte_cnt_d = byte_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      err_code_d = err_code_q;
      err_got_d  = err_got_q;
      err_exp_d  = err_exp_q;
      if (clr_stats) begin
         pkt_cnt_d  = '0;
         byte_cnt_d = '0;
         err_cnt_d  = '0;
         err_flag_d = 1'b0;
         err_code_d = 4'b0000;
         err_got_d  = '0;
         err_exp_d  = '0;
      end else if (acc) begin
         byte_cnt_d = byte_cnt_q + popcount(s_axis_tkeep);
         if (s_axis_tlast) begin
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            if (pkt_bad && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_d = err_cnt_q + 32'd1;
         end
         if ((|beat_err) && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_code_d = beat_err;
            err_got_d  = s_axis_tdata[63:0];
            err_exp_d  = exp_seq;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_q    <= ST_HDR;
         beat_idx_q <= '0;
         pkt_err_q  <= 1'b0;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         err_code_q <= 4'b0000;
         err_got_q  <= '0;
         err_exp_q  <= '0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         pkt_err_q  <= pkt_err_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         err_code_q <= err_code_d;
         err_got_q  <= err_got_d;
         err_exp_q  <= err_exp_d;
      end
   end

   assign stat_pkt_cnt  = pkt_cnt_q;
   assign stat_byte_cnt = byte_cnt_q;
   assign stat_err_cnt  = err_cnt_q;
   assign err_flag      = err_flag_q;
   assign err_code      = err_code_q;
   assign err_got       = err_got_q;
   assign err_exp       = err_exp_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
module tb_axis_pkt_checker;

   localparam int DW     = 512;
   localparam int UW     = 128;
   localparam int CW     = 64;
   localparam int KEEP_W = DW / 8;

   localparam int S_PKT  = 0;
   localparam int S_BYTE = 1;
   localparam int S_ERRC = 2;
   localparam int S_FLAG = 3;
   localparam int S_CODE = 4;
   localparam int S_GOT  = 5;
   localparam int S_EXP  = 6;
   localparam int S_RDY  = 7;
   localparam int S_LOW  = 8;

   logic              clk;
   logic              areset;
   logic [DW-1:0]     s_axis_tdata;
   logic [KEEP_W-1:0] s_axis_tkeep;
   logic [UW-1:0]     s_axis_tuser;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tlast;
   logic [63:0]       cfg_seq_base;
   logic [15:0]       cfg_pkt_beats;
   logic              clr_stats;
   logic [CW-1:0]     stat_pkt_cnt;
   logic [CW-1:0]     stat_byte_cnt;
   logic [31:0]       stat_err_cnt;
   logic              err_flag;
   logic [3:0]        err_code;
   logic [63:0]       err_got;
   logic [63:0]       err_exp;

   axis_pkt_checker #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .CNT_WIDTH           (CW)
   ) dut (
      .clk          (clk),
      .areset       (areset),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .cfg_seq_base (cfg_seq_base),
      .cfg_pkt_beats(cfg_pkt_beats),
      .clr_stats    (clr_stats),
      .stat_pkt_cnt (stat_pkt_cnt),
      .stat_byte_cnt(stat_byte_cnt),
      .stat_err_cnt (stat_err_cnt),
      .err_flag     (err_flag),
      .err_code     (err_code),
      .err_got      (err_got),
      .err_exp      (err_exp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } chk_t;

   chk_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic saw_low  = 1'b0;

   function automatic logic [63:0] dut_val(input int sel);
      case (sel)
         S_PKT:   return stat_pkt_cnt;
         S_BYTE:  return stat_byte_cnt;
         S_ERRC:  return 64'(stat_err_cnt);
         S_FLAG:  return 64'(err_flag);
         S_CODE:  return 64'(err_code);
         S_GOT:   return err_got;
         S_EXP:   return err_exp;
         S_RDY:   return 64'(s_axis_tready);
         S_LOW:   return 64'(saw_low);
         default: return 64'hX;
      endcase
   endfunction

   // Monitor: compares every queued expectation against the DUT on the falling edge.
   initial begin
      chk_t  r;
      logic [63:0] got;
      forever begin
         @(negedge clk);
         if (!areset && !s_axis_tready) saw_low = 1'b1;
         while (sb.size() > 0) begin
            r   = sb.pop_front();
            got = dut_val(r.sel);
            n_checks++;
            if (got !== r.exp) begin
               n_errors++;
               $display("FAIL %s: got %0h expected %0h", r.name, got, r.exp);
            end
         end
      end
   end

   task automatic expect_v(input string name, input int sel, input logic [63:0] v);
      chk_t r;
      r.name = name;
      r.sel  = sel;
      r.exp  = v;
      sb.push_back(r);
   endtask

   task automatic flush();
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #1;
   endtask

   task automatic expect_stats(input string tag, input logic [63:0] pkt, input logic [63:0] bytes,
                               input logic [63:0] errc, input logic [63:0] flag);
      expect_v({tag, "_pkt"},  S_PKT,  pkt);
      expect_v({tag, "_byte"}, S_BYTE, bytes);
      expect_v({tag, "_errc"}, S_ERRC, errc);
      expect_v({tag, "_flag"}, S_FLAG, flag);
      flush();
   endtask

   // Drive one beat (called at posedge+1) and hold it until accepted.
   task automatic beat(input logic [63:0] lo, input logic [KEEP_W-1:0] keep, input logic last,
                       input logic clr);
      logic rd;
      int   tries;
      s_axis_tdata       = '0;
      s_axis_tdata[63:0] = lo;
      s_axis_tkeep       = keep;
      s_axis_tlast       = last;
      s_axis_tvalid      = 1'b1;
      clr_stats          = clr;
      tries              = 0;
      rd                 = 1'b0;
      while (!rd && tries < 64) begin
         @(negedge clk);
         rd = s_axis_tready;
         @(posedge clk);
         tries++;
      end
      if (!rd) begin
         n_checks++;
         n_errors++;
         $display("FAIL beat_accept_timeout: got tready=0 expected acceptance");
      end
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      clr_stats     = 1'b0;
   endtask

   // One packet: header, then payload k=1..nbeats-1 carrying base+k (or bad_val at bad_idx).
   task automatic pkt(input int nbeats, input int bad_idx, input logic [63:0] bad_val,
                      input logic [KEEP_W-1:0] last_keep, input logic clr_last);
      logic [63:0] lo;
      beat(64'hDEAD_BEEF_0000_0000, '1, nbeats == 1, clr_last && nbeats == 1);
      for (int k = 1; k < nbeats; k++) begin
         lo = (k == bad_idx) ? bad_val : cfg_seq_base + 64'(k);
         if (k == nbeats - 1) beat(lo, last_keep, 1'b1, clr_last);
         else                 beat(lo, '1, 1'b0, 1'b0);
      end
   endtask

   task automatic pulse_clr();
      clr_stats = 1'b1;
      @(posedge clk);
      #1;
      clr_stats = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      areset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      expect_v("rst_tready", S_RDY, 64'd0);
      expect_stats("rst", 64'd0, 64'd0, 64'd0, 64'd0);
      expect_v("rst_code", S_CODE, 64'd0);
      expect_v("rst_got",  S_GOT,  64'd0);
      expect_v("rst_exp",  S_EXP,  64'd0);
      flush();
      areset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      cfg_seq_base  = 64'd0;
      cfg_pkt_beats = 16'd22;
      clr_stats     = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);
`ifndef AXIS_PKT_CHECKER_BP_EN
      expect_v("tready_after_reset", S_RDY, 64'd1);
      flush();
`endif

      // 1: ten good 22-beat packets
      for (int p = 0; p < 10; p++) pkt(22, -1, 64'd0, '1, 1'b0);
      expect_stats("good10", 64'd10, 64'd14080, 64'd0, 64'd0);
      pulse_clr();
      expect_stats("clr1", 64'd0, 64'd0, 64'd0, 64'd0);

      // 2: payload beat 5 carries 7
      pkt(22, 5, 64'd7, '1, 1'b0);
      expect_stats("dataerr", 64'd1, 64'd1408, 64'd1, 64'd1);
      expect_v("dataerr_code", S_CODE, 64'h1);
      expect_v("dataerr_got",  S_GOT,  64'd7);
      expect_v("dataerr_exp",  S_EXP,  64'd5);
      flush();
      pulse_clr();

      // 3: contiguous partial last beat, then non-contiguous
      pkt(22, -1, 64'd0, 64'h0000_0000_0000_FFFF, 1'b0);
      expect_stats("keepok", 64'd1, 64'd1360, 64'd0, 64'd0);
      pkt(22, -1, 64'd0, 64'h0000_0000_0000_FF00, 1'b0);
      expect_stats("keepbad", 64'd2, 64'd2712, 64'd1, 64'd1);
      expect_v("keepbad_code", S_CODE, 64'h2);
      expect_v("keepbad_got",  S_GOT,  64'd21);
      flush();
      pulse_clr();

      // 4: short 20-beat, long 25-beat (drained), then good
      pkt(20, -1, 64'd0, '1, 1'b0);
      expect_stats("short", 64'd1, 64'd1280, 64'd1, 64'd1);
      expect_v("short_code", S_CODE, 64'h4);
      flush();
      pkt(25, -1, 64'd0, '1, 1'b0);
      expect_stats("long", 64'd2, 64'd2880, 64'd2, 64'd1);
      expect_v("long_code_first_only", S_CODE, 64'h4);
      flush();
      pkt(22, -1, 64'd0, '1, 1'b0);
      expect_stats("after_long", 64'd3, 64'd4288, 64'd2, 64'd1);

      // 5: reset in the middle of a packet, then a fresh good packet
      beat(64'h1234, '1, 1'b0, 1'b0);
      for (int k = 1; k < 10; k++) beat(64'(k), '1, 1'b0, 1'b0);
      do_reset(2);
      pkt(22, -1, 64'd0, '1, 1'b0);
      expect_stats("post_rst", 64'd1, 64'd1408, 64'd0, 64'd0);

      // 6: clr_stats on the tlast beat of packet 3, then packet 4
      pkt(22, -1, 64'd0, '1, 1'b0);
      pkt(22, -1, 64'd0, '1, 1'b1);
      expect_stats("clr_on_last", 64'd0, 64'd0, 64'd0, 64'd0);
      pkt(22, -1, 64'd0, '1, 1'b0);
      expect_stats("after_clr", 64'd1, 64'd1408, 64'd0, 64'd0);

      // Sequence wraps modulo 2^64
      pulse_clr();
      cfg_seq_base  = 64'hFFFF_FFFF_FFFF_FFFE;
      cfg_pkt_beats = 16'd4;
      pkt(4, -1, 64'd0, '1, 1'b0);
      expect_stats("wrap", 64'd1, 64'd256, 64'd0, 64'd0);

      // cfg_pkt_beats=0 acts as 1: header-only packet is fine
      cfg_seq_base  = 64'd0;
      cfg_pkt_beats = 16'd0;
      pkt(1, -1, 64'd0, '1, 1'b0);
      expect_stats("beats0", 64'd2, 64'd320, 64'd0, 64'd0);

      // Header-only packet when 22 beats are expected is short
      pulse_clr();
      cfg_pkt_beats = 16'd22;
      pkt(1, -1, 64'd0, '1, 1'b0);
      expect_stats("hdr_only", 64'd1, 64'd64, 64'd1, 64'd1);
      expect_v("hdr_only_code", S_CODE, 64'h4);
      flush();

      // Nonzero upper data bits are a data error
      pulse_clr();
      beat(64'd0, '1, 1'b0, 1'b0);
      s_axis_tdata = '0;
      beat(64'd1, '1, 1'b0, 1'b0);
      for (int k = 2; k < 22; k++) begin
         if (k == 3) begin
            s_axis_tdata       = '0;
            s_axis_tdata[100]  = 1'b1;
            s_axis_tdata[63:0] = 64'd3;
            s_axis_tkeep       = '1;
            s_axis_tlast       = 1'b0;
            beat_hold_hi();
         end else begin
            beat(64'(k), '1, k == 21, 1'b0);
         end
      end
      expect_stats("hibits", 64'd1, 64'd1408, 64'd1, 64'd1);
      expect_v("hibits_code", S_CODE, 64'h1);
      expect_v("hibits_got",  S_GOT,  64'd3);
      flush();

`ifdef AXIS_PKT_CHECKER_BP_EN
      expect_v("bp_tready_low_seen", S_LOW, 64'd1);
      flush();
`endif

      flush();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Like beat(), but keeps the preloaded s_axis_tdata (with upper bits set).
   task automatic beat_hold_hi();
      logic rd;
      int   tries;
      s_axis_tvalid = 1'b1;
      tries         = 0;
      rd            = 1'b0;
      while (!rd && tries < 64) begin
         @(negedge clk);
         rd = s_axis_tready;
         @(posedge clk);
         tries++;
      end
      if (!rd) begin
         n_checks++;
         n_errors++;
         $display("FAIL beat_accept_timeout: got tready=0 expected acceptance");
      end
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
